// File: rtl/mips_mc_core.sv
`default_nettype none
// ============================================================================
// Module   : mips_mc_core
// Purpose  : Multi-cycle MIPS32-subset core. The controller FSM, 32x32
//            register file, ALU and PC share one unified memory port.
//            Every access uses a req/ready handshake, so any number of
//            wait states is tolerated.
// Revision : 1.0 - initial release
// ============================================================================
module mips_mc_core #(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
   parameter int unsigned           DBG_REG    = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [31:0]           mem_wdata_o,
   input  logic [31:0]           mem_rdata_i,
   input  logic                  mem_ready_i,
   output logic                  instr_ret_o,
   output logic                  err_o,
   output logic [31:0]           dbg_reg_o
);

   localparam logic [5:0] c_OP_R    = 6'h00;
   localparam logic [5:0] c_OP_J    = 6'h02;
   localparam logic [5:0] c_OP_BEQ  = 6'h04;
   localparam logic [5:0] c_OP_ADDI = 6'h08;
   localparam logic [5:0] c_OP_LW   = 6'h23;
   localparam logic [5:0] c_OP_SW   = 6'h2B;
   localparam logic [5:0] c_FN_ADD  = 6'h20;
   localparam logic [5:0] c_FN_SUB  = 6'h22;
   localparam logic [5:0] c_FN_AND  = 6'h24;
   localparam logic [5:0] c_FN_OR   = 6'h25;
   localparam logic [5:0] c_FN_SLT  = 6'h2A;
   localparam logic [4:0] c_DBG_IDX = 5'(DBG_REG);

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_EXEC   = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWR  = 4'd5,
      S_ALUWB  = 4'd6,
      S_IMMWB  = 4'd7,
      S_MEMWB  = 4'd8,
      S_BRANCH = 4'd9,
      S_JUMP   = 4'd10,
      S_HALT   = 4'd11
   } state_t;

   state_t                state_q;
   logic [ADDR_WIDTH-1:0] pc_q;
   logic [31:0]           ir_q;
   logic [31:0]           a_q;
   logic [31:0]           b_q;
   logic [31:0]           alu_q;
   logic [31:0]           mdr_q;
   logic [31:0]           regs_q [32];
   logic                  instr_ret_q;
   logic                  err_q;

   // Instruction fields, always taken from the latched IR
   logic [5:0]  op;
   logic [5:0]  funct;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [31:0] imm_sext;

   assign op       = ir_q[31:26];
   assign rs       = ir_q[25:21];
   assign rt       = ir_q[20:16];
   assign rd       = ir_q[15:11];
   assign funct    = ir_q[5:0];
   assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};

   logic                  legal;
   logic [31:0]           alu_d;
   logic                  misaligned;
   logic                  mem_fire;
   logic [ADDR_WIDTH-1:0] br_pc_d;
   logic [31:0]           jmp32;
   logic [ADDR_WIDTH-1:0] jmp_pc_d;

   // Opcode/funct legality check used in DECODE
   always_comb begin
      legal = 1'b0;
      case (op)
         c_OP_R:    legal = (funct == c_FN_ADD) || (funct == c_FN_SUB) ||
                            (funct == c_FN_AND) || (funct == c_FN_OR)  ||
                            (funct == c_FN_SLT);
         c_OP_LW, c_OP_SW, c_OP_BEQ, c_OP_ADDI, c_OP_J: legal = 1'b1;
         default:   legal = 1'b0;
      endcase
   end

   // ALU: R-type uses B, everything else (addi/lw/sw) uses the immediate
   always_comb begin
      alu_d = a_q + imm_sext;
      if (op == c_OP_R) begin
         case (funct)
            c_FN_SUB: alu_d = a_q - b_q;
            c_FN_AND: alu_d = a_q & b_q;
            c_FN_OR:  alu_d = a_q | b_q;
            c_FN_SLT: alu_d = {31'd0, ($signed(a_q) < $signed(b_q))};
            default:  alu_d = a_q + b_q;
         endcase
      end
   end

   assign misaligned = |alu_d[1:0];
   // pc_q already points past the branch/jump, as in the classic MIPS datapath
   assign br_pc_d    = pc_q + ADDR_WIDTH'(imm_sext << 2);
   assign jmp32      = (32'(pc_q) & 32'hF000_0000) | {4'd0, ir_q[25:0], 2'b00};
   assign jmp_pc_d   = jmp32[ADDR_WIDTH-1:0];

   // Memory port decoded from state so it holds steady through wait states
   always_comb begin
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      case (state_q)
         S_FETCH: begin
            mem_req_o  = 1'b1;
            mem_addr_o = pc_q;
         end
         S_MEMRD: begin
            mem_req_o  = 1'b1;
            mem_addr_o = alu_q[ADDR_WIDTH-1:0];
         end
         S_MEMWR: begin
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = alu_q[ADDR_WIDTH-1:0];
            mem_wdata_o = b_q;
         end
         default: ;
      endcase
   end

   assign mem_fire    = mem_req_o & mem_ready_i;
   assign instr_ret_o = instr_ret_q;
   assign err_o       = err_q;
   assign dbg_reg_o   = regs_q[c_DBG_IDX];

   // Controller FSM with datapath registers and register file
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         pc_q        <= RESET_PC;
         ir_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         alu_q       <= '0;
         mdr_q       <= '0;
         instr_ret_q <= 1'b0;
         err_q       <= 1'b0;
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         instr_ret_q <= 1'b0;
         case (state_q)
            S_IDLE: state_q <= S_FETCH;
            S_FETCH: begin
               if (mem_fire) begin
                  ir_q    <= mem_rdata_i;
                  pc_q    <= pc_q + ADDR_WIDTH'(4);
                  state_q <= S_DECODE;
               end
            end
            S_DECODE: begin
               a_q <= regs_q[rs];
               b_q <= regs_q[rt];
               if (!legal) begin
                  err_q   <= 1'b1;
                  state_q <= S_HALT;
               end else if (op == c_OP_BEQ) begin
                  state_q <= S_BRANCH;
               end else if (op == c_OP_J) begin
                  state_q <= S_JUMP;
               end else begin
                  state_q <= S_EXEC;
               end
            end
            S_EXEC: begin
               alu_q <= alu_d;
               case (op)
                  c_OP_R:    state_q <= S_ALUWB;
                  c_OP_ADDI: state_q <= S_IMMWB;
                  c_OP_LW, c_OP_SW: begin
                     // A misaligned data access never reaches the bus
                     if (misaligned) begin
                        err_q   <= 1'b1;
                        state_q <= S_HALT;
                     end else begin
                        state_q <= (op == c_OP_LW) ? S_MEMRD : S_MEMWR;
                     end
                  end
                  default: begin
                     err_q   <= 1'b1;
                     state_q <= S_HALT;
                  end
               endcase
            end
            S_MEMRD: begin
               if (mem_fire) begin
                  mdr_q   <= mem_rdata_i;
                  state_q <= S_MEMWB;
               end
            end
            S_MEMWR: begin
               if (mem_fire) begin
                  instr_ret_q <= 1'b1;
                  state_q     <= S_FETCH;
               end
            end
            S_ALUWB: begin
               if (rd != 5'd0) regs_q[rd] <= alu_q;
               instr_ret_q <= 1'b1;
               state_q     <= S_FETCH;
            end
            S_IMMWB: begin
               if (rt != 5'd0) regs_q[rt] <= alu_q;
               instr_ret_q <= 1'b1;
               state_q     <= S_FETCH;
            end
            S_MEMWB: begin
               if (rt != 5'd0) regs_q[rt] <= mdr_q;
               instr_ret_q <= 1'b1;
               state_q     <= S_FETCH;
            end
            S_BRANCH: begin
               if (a_q == b_q) pc_q <= br_pc_d;
               instr_ret_q <= 1'b1;
               state_q     <= S_FETCH;
            end
            S_JUMP: begin
               pc_q        <= jmp_pc_d;
               instr_ret_q <= 1'b1;
               state_q     <= S_FETCH;
            end
            S_HALT:  state_q <= S_HALT;
            default: state_q <= S_HALT;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mips_mc_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_mc_core
// Purpose  : Self-checking bench for mips_mc_core. A memory responder with
//            configurable wait states serves the core; an instruction-level
//            interpreter predicts fetch addresses, data accesses, $s0 and
//            per-instruction cycle counts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_mc_core;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_req, mem_we, mem_ready, instr_ret, err;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, dbg_reg;

   always #5 clk = ~clk;

   mips_mc_core #(.ADDR_WIDTH(32), .RESET_PC(32'h0), .DBG_REG(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .mem_req_o   (mem_req),
      .mem_we_o    (mem_we),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .mem_rdata_i (mem_rdata),
      .mem_ready_i (mem_ready),
      .instr_ret_o (instr_ret),
      .err_o       (err),
      .dbg_reg_o   (dbg_reg)
   );

   int errors = 0;
   int checks = 0;

   logic [31:0] mem   [0:255];
   logic [31:0] m_reg [0:31];
   logic [31:0] m_pc;
   bit          m_halt;

   bit          pend_valid, pend_data, pend_we;
   int          pend_start, pend_base, pend_waits;
   logic [31:0] pend_addr, pend_wdata, pend_val, pend_npc;
   logic [4:0]  pend_wr;

   bit          busy;
   int          left;
   logic [31:0] a_addr, a_wdata, last_fetch;
   logic        a_we;
   int          cyc_no = 0;
   int          nret = 0;
   int          fixed_wait = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                         input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] enc_j(input logic [25:0] t);
      return {6'h02, t};
   endfunction

   function automatic int pick_wait();
      if (fixed_wait >= 0) return fixed_wait;
      return int'($urandom_range(0, 3));
   endfunction

   function automatic logic [4:0] pick_reg();
      case ($urandom_range(0, 4))
         0: return 5'd0;
         1: return 5'd8;
         2: return 5'd9;
         3: return 5'd10;
         default: return 5'd16;
      endcase
   endfunction

   // Interpret the instruction at m_pc: predict its effects and cycle cost
   task automatic model_fetch();
      logic [31:0] ins, a, b, simm, ea;
      logic [5:0]  op, fn;
      logic [4:0]  rs, rt, rd;
      bit          bad;
      ins  = mem[m_pc[9:2]];
      op   = ins[31:26]; fn = ins[5:0];
      rs   = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
      simm = {{16{ins[15]}}, ins[15:0]};
      a    = m_reg[rs]; b = m_reg[rt];
      ea   = a + simm;
      bad  = 0;
      pend_valid = 1; pend_start = cyc_no; pend_waits = 0;
      pend_data = 0; pend_we = 0; pend_addr = 0; pend_wdata = 0;
      pend_wr = 0; pend_val = 0; pend_npc = m_pc + 4; pend_base = 4;
      case (op)
         6'h00: begin
            pend_wr = rd;
            case (fn)
               6'h20: pend_val = a + b;
               6'h22: pend_val = a - b;
               6'h24: pend_val = a & b;
               6'h25: pend_val = a | b;
               6'h2A: pend_val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
               default: bad = 1;
            endcase
         end
         6'h08: begin pend_wr = rt; pend_val = ea; end
         6'h23: begin
            if (ea[1:0] != 2'b00) bad = 1;
            else begin
               pend_data = 1; pend_addr = ea; pend_base = 5;
               pend_wr = rt; pend_val = mem[ea[9:2]];
            end
         end
         6'h2B: begin
            if (ea[1:0] != 2'b00) bad = 1;
            else begin pend_data = 1; pend_we = 1; pend_addr = ea; pend_wdata = b; end
         end
         6'h04: begin
            pend_base = 3;
            if (a == b) pend_npc = m_pc + 4 + (simm << 2);
         end
         6'h02: begin
            pend_base = 3;
            pend_npc  = {pend_npc[31:28], ins[25:0], 2'b00};
         end
         default: bad = 1;
      endcase
      if (bad) begin m_halt = 1; pend_valid = 0; end
   endtask

   // One clock: called at a falling edge, serves memory, returns at the next falling edge
   task automatic cycle();
      cyc_no++;
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      if (instr_ret) begin
         if (!pend_valid) chk("spurious_ret", {31'd0, instr_ret}, 32'd0);
         else begin
            chk("ret_cycles", cyc_no - pend_start, pend_base + pend_waits);
            chk("ret_data_done", {31'd0, pend_data}, 32'd0);
            if (pend_wr != 5'd0) m_reg[pend_wr] = pend_val;
            m_pc = pend_npc;
            pend_valid = 0;
            nret++;
            chk("ret_dbg_s0", dbg_reg, m_reg[16]);
            chk("ret_err", {31'd0, err}, 32'd0);
         end
      end
      if (mem_req) begin
         if (!busy) begin
            if (m_halt) chk("halt_req", {31'd0, mem_req}, 32'd0);
            else if (!pend_valid) begin
               chk("fetch_addr", mem_addr, m_pc);
               chk("fetch_we", {31'd0, mem_we}, 32'd0);
               last_fetch = mem_addr;
               model_fetch();
            end else if (!pend_data) chk("extra_req", {31'd0, mem_req}, 32'd0);
            else begin
               chk("data_addr", mem_addr, pend_addr);
               chk("data_we", {31'd0, mem_we}, {31'd0, pend_we});
               if (pend_we) chk("data_wdata", mem_wdata, pend_wdata);
               pend_data = 0;
            end
            a_addr = mem_addr; a_we = mem_we; a_wdata = mem_wdata;
            busy = 1; left = pick_wait();
         end else begin
            chk("stable_addr", mem_addr, a_addr);
            chk("stable_we", {31'd0, mem_we}, {31'd0, a_we});
            chk("stable_wdata", mem_wdata, a_wdata);
         end
         if (left == 0) begin
            mem_ready = 1'b1;
            busy = 0;
            if (a_we) mem[a_addr[9:2]] = a_wdata;
            else      mem_rdata = mem[a_addr[9:2]];
         end else begin
            left--;
            if (pend_valid) pend_waits++;
         end
      end else if (busy) begin
         chk("req_dropped", {31'd0, mem_req}, 32'd1);
         busy = 0;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
      @(negedge clk);
      chk("rst_req", {31'd0, mem_req}, 32'd0);
      chk("rst_we", {31'd0, mem_we}, 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      chk("rst_ret", {31'd0, instr_ret}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_dbg", dbg_reg, 32'd0);
      rst_n = 1'b1;
      m_pc = 32'h0; m_halt = 0; pend_valid = 0; pend_data = 0; busy = 0; left = 0;
      for (int i = 0; i < 32; i++) m_reg[i] = '0;
      #1 chk("idle_req", {31'd0, mem_req}, 32'd0);
      @(negedge clk);
      chk("first_req", {31'd0, mem_req}, 32'd1);
   endtask

   task automatic run_instrs(input int n);
      int target;
      int bound;
      target = nret + n;
      bound  = n * 16 + 20;
      while (nret < target && bound > 0) begin
         cycle();
         bound--;
      end
      chk("retire_count", nret, target);
   endtask

   task automatic gen_random();
      logic [4:0]  rs, rt, rd;
      logic [5:0]  fn;
      int          t;
      for (int w = 0; w < 127; w++) begin
         rs = pick_reg(); rt = pick_reg(); rd = pick_reg();
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: begin
               case ($urandom_range(0, 4))
                  0: fn = 6'h20;
                  1: fn = 6'h22;
                  2: fn = 6'h24;
                  3: fn = 6'h25;
                  default: fn = 6'h2A;
               endcase
               mem[w] = enc_r(rs, rt, rd, fn);
            end
            5: mem[w] = enc_i(6'h08, rs, rt, 16'($urandom));
            6: mem[w] = enc_i(6'h23, 5'd0, rt, 16'(32'h200 + 4 * $urandom_range(0, 127)));
            7: mem[w] = enc_i(6'h2B, 5'd0, rt, 16'(32'h200 + 4 * $urandom_range(0, 127)));
            8: begin
               t = int'($urandom_range(0, 127));
               mem[w] = enc_i(6'h04, rs, rt, 16'(t - (w + 1)));
            end
            default: mem[w] = enc_j(26'($urandom_range(0, 127)));
         endcase
      end
      mem[127] = enc_j(26'($urandom_range(0, 126)));
      for (int w = 128; w < 256; w++) mem[w] = $urandom;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int guard;
      mem_ready = 1'b0; mem_rdata = '0;
      for (int i = 0; i < 256; i++) mem[i] = '0;

      // Directed program: arithmetic, branch, jump, store/load
      mem[0]  = enc_i(6'h08, 5'd0, 5'd16, 16'd5);
      mem[1]  = enc_i(6'h08, 5'd0, 5'd8, 16'd7);
      mem[2]  = enc_i(6'h08, 5'd0, 5'd9, 16'hFFFD);
      mem[3]  = enc_r(5'd8, 5'd9, 5'd16, 6'h20);
      mem[4]  = enc_r(5'd9, 5'd8, 5'd16, 6'h2A);
      mem[5]  = enc_i(6'h04, 5'd8, 5'd9, 16'd5);
      mem[6]  = enc_j(26'h40);
      mem[64] = enc_i(6'h2B, 5'd0, 5'd8, 16'd8);
      mem[65] = enc_i(6'h23, 5'd0, 5'd16, 16'd8);
      mem[66] = enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF);

      fixed_wait = 0;
      do_reset();
      run_instrs(1);
      chk("addi_s0", dbg_reg, 32'd5);
      chk("addi_err", {31'd0, err}, 32'd0);
      run_instrs(3);
      chk("add_s0", dbg_reg, 32'd4);
      run_instrs(1);
      chk("slt_s0", dbg_reg, 32'd1);
      run_instrs(1);
      chk("beq_not_taken_fetch", last_fetch, 32'h18);
      run_instrs(1);
      chk("j_fetch", last_fetch, 32'h100);
      fixed_wait = 3;
      run_instrs(2);
      chk("lw_s0", dbg_reg, 32'd7);
      chk("sw_mem8", mem[2], 32'd7);
      fixed_wait = 0;
      run_instrs(2);
      chk("beq_taken_fetch", last_fetch, 32'h108);

      // Illegal opcode parks the core
      mem[0] = 32'hFC00_0000;
      do_reset();
      for (int i = 0; i < 4; i++) cycle();
      chk("illegal_err", {31'd0, err}, 32'd1);
      for (int i = 0; i < 20; i++) begin
         chk("illegal_halt_req", {31'd0, mem_req}, 32'd0);
         chk("illegal_halt_ret", {31'd0, instr_ret}, 32'd0);
         cycle();
      end

      // Misaligned load parks the core without touching memory
      mem[0] = enc_i(6'h23, 5'd0, 5'd16, 16'd6);
      do_reset();
      for (int i = 0; i < 5; i++) cycle();
      chk("misalign_err", {31'd0, err}, 32'd1);
      chk("misalign_s0", dbg_reg, 32'd0);
      for (int i = 0; i < 20; i++) begin
         chk("misalign_halt_req", {31'd0, mem_req}, 32'd0);
         chk("misalign_halt_ret", {31'd0, instr_ret}, 32'd0);
         cycle();
      end

      // Random programs with random wait states
      fixed_wait = -1;
      for (int p = 0; p < 4; p++) begin
         gen_random();
         do_reset();
         run_instrs(60);
      end

      // Reset during a stalled store aborts it
      mem[0]   = enc_i(6'h08, 5'd0, 5'd8, 16'd7);
      mem[1]   = enc_i(6'h2B, 5'd0, 5'd8, 16'h200);
      mem[2]   = enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF);
      mem[128] = 32'hDEAD_BEEF;
      fixed_wait = 6;
      do_reset();
      run_instrs(1);
      guard = 0;
      while (!(busy && a_we && left <= 3) && guard < 20) begin
         cycle();
         guard++;
      end
      chk("memwr_waiting_we", {31'd0, mem_we}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_req", {31'd0, mem_req}, 32'd0);
      chk("abort_we", {31'd0, mem_we}, 32'd0);
      chk("abort_addr", mem_addr, 32'd0);
      fixed_wait = 0;
      do_reset();
      chk("abort_mem_untouched", mem[128], 32'hDEAD_BEEF);
      run_instrs(2);
      chk("restart_store", mem[128], 32'd7);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
